// File: rtl/deca_key_pio_pkg.sv
// deca_key_pio_pkg
//   Shared constants for the DECA key/switch input PIO: register word
//   offsets and the reset values used by the top level and the debounce
//   channel.
package deca_key_pio_pkg;

   localparam logic [2:0] ADDR_DATA = 3'd0;
   localparam logic [2:0] ADDR_RISE = 3'd1;
   localparam logic [2:0] ADDR_MASK = 3'd2;
   localparam logic [2:0] ADDR_EDGE = 3'd3;
   localparam logic [2:0] ADDR_FALL = 3'd4;
   localparam logic [2:0] ADDR_DEB  = 3'd5;

   localparam int unsigned DEB_W_DEFAULT   = 16;
   localparam int unsigned DEB_DEFAULT_VAL = 50000;

endpackage

// File: rtl/deca_key_debounce.sv
// deca_key_debounce
//   One debounce channel. The filtered level follows the synchronised input
//   only after the two have disagreed for max(thresh,1) consecutive cycles.
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset
//   d2       synchronised input level
//   thresh   required mismatch run length (0 behaves as 1)
//   deb      filtered level
module deca_key_debounce
   import deca_key_pio_pkg::*;
#(
   parameter int unsigned DEB_W       = DEB_W_DEFAULT,
   parameter logic        RESET_LEVEL = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             d2,
   input  logic [DEB_W-1:0] thresh,
   output logic             deb
);

   logic [DEB_W-1:0] cnt;
   logic [DEB_W-1:0] limit;
   logic [DEB_W:0]   cnt_inc;

   assign limit   = (thresh == '0) ? DEB_W'(1) : thresh;
   assign cnt_inc = {1'b0, cnt} + 1'b1;

   // A lowered threshold is honoured immediately by the >= compare, so a
   // count already past the new limit commits on the next mismatch cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         deb <= RESET_LEVEL;
         cnt <= '0;
      end else if (d2 == deb) begin
         cnt <= '0;
      end else if (cnt_inc >= {1'b0, limit}) begin
         deb <= d2;
         cnt <= '0;
      end else if (!(&cnt)) begin
         cnt <= cnt_inc[DEB_W-1:0];
      end
   end

endmodule

// File: rtl/deca_key_pio.sv
// deca_key_pio
//   Avalon-MM input PIO for DECA push-buttons/switches: two-flop
//   synchroniser, optional per-channel debounce, selectable rising/falling
//   edge detect, write-1-to-clear edge capture and a level interrupt.
//   Offsets 0, 2 and 3 match the legacy 2-bit key PIO.
// Build option:
//   DECA_KEY_PIO_DEBOUNCE_EN  enables the per-channel debounce counters and
//                             the DEB_THRESH register; otherwise the filtered
//                             level is simply d2 delayed by one register.
// Ports:
//   clk, reset_n  system clock, synchronous active-low reset
//   address       word address (0..7)
//   chipselect    slave select
//   write_n       active-low write strobe
//   writedata     write data
//   in_port       asynchronous key inputs
//   readdata      registered read data (1-cycle latency, always follows address)
//   irq           level interrupt, |(EDGE_CAPTURE & IRQ_MASK)
module deca_key_pio
   import deca_key_pio_pkg::*;
#(
   parameter int unsigned      WIDTH       = 2,
   parameter logic [WIDTH-1:0] RESET_LEVEL = {WIDTH{1'b1}},
   parameter int unsigned      DEB_W       = DEB_W_DEFAULT,
   parameter logic [DEB_W-1:0] DEB_DEFAULT = DEB_W'(DEB_DEFAULT_VAL)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] d1;
   logic [WIDTH-1:0] d2;
   logic [WIDTH-1:0] deb;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] rise_en;
   logic [WIDTH-1:0] fall_en;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] edge_evt;
   logic [WIDTH-1:0] clr_bits;
   logic [31:0]      rd_mux;
   logic             wr;

   // Upper writedata bits are architecturally ignored.
   logic unused_wdata;
   assign unused_wdata = ^writedata;

   assign wr = chipselect & ~write_n;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         d1   <= RESET_LEVEL;
         d2   <= RESET_LEVEL;
         prev <= RESET_LEVEL;
      end else begin
         d1   <= in_port;
         d2   <= d1;
         prev <= deb;
      end
   end

`ifdef DECA_KEY_PIO_DEBOUNCE_EN
   logic [DEB_W-1:0] deb_thresh;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         deb_thresh <= DEB_DEFAULT;
      end else if (wr && address == ADDR_DEB) begin
         deb_thresh <= writedata[DEB_W-1:0];
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : gen_deb
      deca_key_debounce #(
         .DEB_W       (DEB_W),
         .RESET_LEVEL (RESET_LEVEL[i])
      ) u_deb (
         .clk     (clk),
         .reset_n (reset_n),
         .d2      (d2[i]),
         .thresh  (deb_thresh),
         .deb     (deb[i])
      );
   end
`else
   localparam int unsigned unused_deb_default = 32'(DEB_DEFAULT);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         deb <= RESET_LEVEL;
      end else begin
         deb <= d2;
      end
   end
`endif

   assign edge_evt = (rise_en & deb & ~prev) | (fall_en & ~deb & prev);
   assign clr_bits = (wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rise_en  <= '0;
         fall_en  <= '0;
         irq_mask <= '0;
         edge_cap <= '0;
      end else begin
         if (wr && address == ADDR_RISE) rise_en  <= writedata[WIDTH-1:0];
         if (wr && address == ADDR_FALL) fall_en  <= writedata[WIDTH-1:0];
         if (wr && address == ADDR_MASK) irq_mask <= writedata[WIDTH-1:0];
         // OR-ing the event in after the clear means a coincident edge survives.
         edge_cap <= (edge_cap & ~clr_bits) | edge_evt;
      end
   end

   assign irq = |(edge_cap & irq_mask);

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA: rd_mux = 32'(deb);
         ADDR_RISE: rd_mux = 32'(rise_en);
         ADDR_MASK: rd_mux = 32'(irq_mask);
         ADDR_EDGE: rd_mux = 32'(edge_cap);
         ADDR_FALL: rd_mux = 32'(fall_en);
`ifdef DECA_KEY_PIO_DEBOUNCE_EN
         ADDR_DEB:  rd_mux = 32'(deb_thresh);
`endif
         default:   rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         readdata <= '0;
      end else begin
         readdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_deca_key_pio.sv
module tb_deca_key_pio;

   logic        clk;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [1:0]  in_port;
   logic [31:0] readdata;
   logic        irq;

   int n_pass  = 0;
   int n_total = 0;

`ifdef DECA_KEY_PIO_DEBOUNCE_EN
   localparam bit DEB_ON  = 1'b1;
   localparam int M_DIR   = 4;
`else
   localparam bit DEB_ON  = 1'b0;
   localparam int M_DIR   = 1;
`endif

   deca_key_pio dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Filtered level flips once the last M samples of the synchronised input
   // all disagree with it (M = max(thresh,1) with debounce, else 1).
   bit          m_valid = 1'b0;
   logic [1:0]  m_d1, m_d2, m_deb, m_prev, m_rise, m_fall, m_mask, m_cap;
   int          m_thr;
   logic [31:0] m_rd;
   logic        m_irq;
   bit          h0[$], h1[$];

   function automatic bit run_ok(input bit q[$], input int m, input bit v);
      if (q.size() < m) return 1'b0;
      for (int k = q.size() - m; k < q.size(); k++)
         if (q[k] != v) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      logic [1:0]  evt, clr, n_deb;
      logic [31:0] n_rd;
      int          m;
      bit          w;
      if (!reset_n) begin
         m_d1 = 2'b11; m_d2 = 2'b11; m_deb = 2'b11; m_prev = 2'b11;
         m_rise = 0; m_fall = 0; m_mask = 0; m_cap = 0;
         m_thr = 50000; m_rd = 0;
         h0.delete(); h1.delete();
         m_valid = 1'b1;
      end else begin
         w = chipselect && !write_n;
         case (address)
            3'd0: n_rd = {30'd0, m_deb};
            3'd1: n_rd = {30'd0, m_rise};
            3'd2: n_rd = {30'd0, m_mask};
            3'd3: n_rd = {30'd0, m_cap};
            3'd4: n_rd = {30'd0, m_fall};
            3'd5: n_rd = DEB_ON ? 32'(m_thr) : 32'd0;
            default: n_rd = 0;
         endcase
         m = DEB_ON ? ((m_thr == 0) ? 1 : m_thr) : 1;
         evt = (m_rise & m_deb & ~m_prev) | (m_fall & ~m_deb & m_prev);
         clr = (w && address == 3'd3) ? writedata[1:0] : 2'b00;
         h0.push_back(m_d2[0]); h1.push_back(m_d2[1]);
         if (h0.size() > 128) void'(h0.pop_front());
         if (h1.size() > 128) void'(h1.pop_front());
         n_deb = m_deb;
         if (run_ok(h0, m, ~m_deb[0])) n_deb[0] = ~m_deb[0];
         if (run_ok(h1, m, ~m_deb[1])) n_deb[1] = ~m_deb[1];
         m_cap  = (m_cap & ~clr) | evt;
         m_prev = m_deb;
         m_deb  = n_deb;
         m_d2   = m_d1;
         m_d1   = in_port;
         if (w && address == 3'd1) m_rise = writedata[1:0];
         if (w && address == 3'd2) m_mask = writedata[1:0];
         if (w && address == 3'd4) m_fall = writedata[1:0];
         if (w && address == 3'd5 && DEB_ON) m_thr = int'(writedata[15:0]);
         m_rd = n_rd;
      end
      m_irq = |(m_cap & m_mask);
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("readdata", readdata, m_rd);
         chk("irq", 32'(irq), 32'(m_irq));
      end
   end

   // ---------------- stimulus ----------------
   task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1; writedata = $urandom;
   endtask

   task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      address = a;
      @(negedge clk);
      d = readdata;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      logic [31:0] d, exp;
      int          k;
      reset_n = 1'b0; in_port = 2'b11; chipselect = 1'b0; write_n = 1'b1;
      address = 3'd0; writedata = 32'd0;
      idle(3);
      reset_n = 1'b1;

      // reset state
      for (int a = 0; a < 8; a++) begin
         rd_reg(3'(a), d);
         exp = (a == 0) ? 32'd3 : ((a == 5 && DEB_ON) ? 32'd50000 : 32'd0);
         chk("rst_read", d, exp);
      end
      chk("rst_irq", 32'(irq), 32'd0);

      // rising-edge latency, falling ignored
      wr_reg(3'd5, 32'd4); wr_reg(3'd1, 32'd1); wr_reg(3'd4, 32'd0); wr_reg(3'd2, 32'd1);
      @(negedge clk); in_port[0] = 1'b0;
      idle(10);
      chk("fall_ignored_irq", 32'(irq), 32'd0);
      in_port[0] = 1'b1;
      k = 0;
      do begin @(negedge clk); k++; end while (!irq && k < 20);
      chk("rise_latency", k, 2 + M_DIR + 1);
      rd_reg(3'd3, d);
      chk("rise_cap", d, 32'd1);
      wr_reg(3'd3, 32'd3);
      chk("clr_irq", 32'(irq), 32'd0);

      // glitch filtering on channel 1 (falling edges only)
      wr_reg(3'd4, 32'd2);
      @(negedge clk); in_port[1] = 1'b0;
      idle(3); in_port[1] = 1'b1;
      idle(10);
      rd_reg(3'd3, d);
      chk("glitch3_cap", d, DEB_ON ? 32'd0 : 32'd2);
      rd_reg(3'd0, d);
      chk("glitch3_data", d, 32'd3);
      wr_reg(3'd3, 32'd3);
      @(negedge clk); in_port[1] = 1'b0;
      idle(4); in_port[1] = 1'b1;
      idle(12);
      rd_reg(3'd3, d);
      chk("pulse4_cap", d, 32'd2);
      wr_reg(3'd3, 32'd3);

      // both edges, both channels, partial clear
      wr_reg(3'd1, 32'd3); wr_reg(3'd4, 32'd3);
      @(negedge clk); in_port = 2'b00;
      idle(12);
      rd_reg(3'd3, d);
      chk("both_cap", d, 32'd3);
      wr_reg(3'd3, 32'd1);
      rd_reg(3'd3, d);
      chk("partial_clr", d, 32'd2);
      @(negedge clk); in_port = 2'b11;
      idle(12);
      wr_reg(3'd3, 32'd3);

      // clear coinciding with a capture on bit 0
      wr_reg(3'd4, 32'd0);
      @(negedge clk); in_port[0] = 1'b0;
      idle(12);
      wr_reg(3'd3, 32'd3);
      @(negedge clk); in_port[0] = 1'b1;
      repeat (2 + M_DIR) @(negedge clk);
      address = 3'd3; chipselect = 1'b1; write_n = 1'b0; writedata = 32'd1;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      rd_reg(3'd3, d);
      chk("set_wins", d, 32'd1);
      chk("set_wins_irq", 32'(irq), 32'd1);
      wr_reg(3'd3, 32'd3);

      // reset in the middle of a debounce count
      @(negedge clk); in_port[1] = 1'b0;
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk); reset_n = 1'b1;
`ifdef DECA_KEY_PIO_DEBOUNCE_EN
      rd_reg(3'd0, d);
      chk("rst_mid_deb", d, 32'd3);
      wr_reg(3'd5, 32'd4);
      idle(2);
      rd_reg(3'd0, d);
      chk("fresh_count", d, 32'd1);
`endif
      in_port = 2'b11;
      idle(12);

      // randomized traffic against the model
      for (int it = 0; it < 400; it++) begin
         int op;
         op = $urandom_range(0, 9);
         if (op <= 3) begin
            @(negedge clk); in_port = 2'($urandom);
            idle($urandom_range(1, 8));
         end else if (op <= 6) begin
            logic [2:0] a;
            a = 3'($urandom);
            wr_reg(a, (a == 3'd5) ? 32'($urandom_range(0, 6)) : $urandom);
         end else if (op == 7) begin
            @(negedge clk);
            address = 3'($urandom); chipselect = 1'b0; write_n = 1'b0; writedata = $urandom;
            @(negedge clk); write_n = 1'b1;
         end else if (op == 8) begin
            rd_reg(3'($urandom), d);
         end else if ($urandom_range(0, 4) == 0) begin
            @(negedge clk); reset_n = 1'b0;
            @(negedge clk); reset_n = 1'b1;
            wr_reg(3'd5, 32'($urandom_range(0, 6)));
         end
      end
      idle(5);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
